// File: rtl/huff_pkg.sv
// Shared types for the Huffman stages: FSM state encoding, table base defaults
// and the single-port memory request bundle driven by BT/CT/encode.
package huff_pkg;

    localparam logic [15:0] LEN_BASE_DEF  = 16'd0;
    localparam logic [15:0] CODE_BASE_DEF = 16'd128;
    localparam int          MAX_LEN_DEF   = 8;

    typedef enum logic [3:0] {
        IDLE,
        RD_SYM,
        WT_SYM,
        RD_LEN,
        WT_LEN,
        RD_CODE,
        WT_CODE,
        MERGE,
        WR_BYTE,
        WT_W,
        FLUSH,
        WT_F,
        TRAIL,
        WT_T,
        DONE
    } huff_state_e;

    // One bus request per cycle; a stage never raises rd and wr together.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        rd;
        logic        wr;
    } mem_req_t;

    localparam mem_req_t MEM_IDLE = '{addr: 16'd0, wdata: 8'd0, rd: 1'b0, wr: 1'b0};

    function automatic mem_req_t mem_read(input logic [15:0] addr);
        mem_req_t r;
        r       = MEM_IDLE;
        r.addr  = addr;
        r.rd    = 1'b1;
        return r;
    endfunction

    function automatic mem_req_t mem_write(input logic [15:0] addr, input logic [7:0] data);
        mem_req_t r;
        r       = MEM_IDLE;
        r.addr  = addr;
        r.wdata = data;
        r.wr    = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/huff_bitpack.sv
// MSB-first bit packer: 16-bit accumulator plus fill count, merged one code at
// a time and drained a byte at a time from the top.
module huff_bitpack
    import huff_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       merge,
    input  logic       shift,
    input  logic [7:0] code,
    input  logic [3:0] len,
    output logic [7:0] byte_out,
    output logic [3:0] nb,
    output logic       byte_ready
);

    logic [15:0] acc;

    // Bits of the table entry below the code length are don't-care.
    function automatic logic [7:0] mask_code(input logic [7:0] c, input logic [3:0] l);
        logic [7:0] m;
        m = 8'hFF << (4'd8 - l);
        return c & m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= 16'd0;
            nb  <= 4'd0;
        end else if (merge) begin
            acc <= acc | ({mask_code(code, len), 8'h00} >> nb);
            nb  <= nb + len;
        end else if (shift) begin
            acc <= {acc[7:0], 8'h00};
            nb  <= nb - 4'd8;
        end
    end

    // nb < 8 whenever a merge happens, so the sum never exceeds 15.
    assign byte_ready = (nb + len) >= 4'd8;
    assign byte_out   = acc[15:8];

endmodule

// File: rtl/huff_encode.sv
// Huffman encoder: reads symbols and their (length, code) table entries from
// shared memory and writes the packed bitstream back MSB-first.
// Optional: define HUFF_ENC_TRAILER_EN to append a last-byte valid-bit count.
module huff_encode
    import huff_pkg::*;
#(
    parameter logic [15:0] SRC_BASE  = 16'd1024,
    parameter logic [15:0] DST_BASE  = 16'd2048,
    parameter logic [15:0] LEN_BASE  = LEN_BASE_DEF,
    parameter logic [15:0] CODE_BASE = CODE_BASE_DEF,
    parameter int          MAX_LEN   = MAX_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  sym_count,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data_R,
    output logic [7:0]  mem_data_W,
    output logic        mem_R,
    output logic        mem_W,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [12:0] out_bits
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    huff_state_e state, state_d;
    mem_req_t    req;

    logic [9:0]  cnt;
    logic [9:0]  i;
    logic [10:0] j;
    logic [7:0]  sym;
    logic [3:0]  len;
    logic [7:0]  code;

    logic [7:0]  byte_out;
    logic [3:0]  nb;
    logic        byte_ready;
    logic        last;
    logic        len_bad;

    assign last    = (i == cnt - 10'd1);
    assign len_bad = (mem_data_R == 8'd0) || (mem_data_R > MAX_LEN_B);

`ifdef HUFF_ENC_TRAILER_EN
    // Valid bits in the final data byte: 1..8, or 0 when nothing was emitted.
    logic [7:0] trailer_val;
    assign trailer_val = (out_bits == 13'd0)     ? 8'd0 :
                         (out_bits[2:0] == 3'd0) ? 8'd8 : {5'd0, out_bits[2:0]};
`endif

    huff_bitpack u_bitpack (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE && start),
        .merge      (state == MERGE),
        .shift      (state == WR_BYTE),
        .code       (code),
        .len        (len),
        .byte_out   (byte_out),
        .nb         (nb),
        .byte_ready (byte_ready)
    );

    always_comb begin
        state_d = state;
        req     = MEM_IDLE;
        unique case (state)
            IDLE:    if (start) state_d = (sym_count == 10'd0) ? DONE : RD_SYM;
            RD_SYM:  begin
                req     = mem_read(SRC_BASE + {6'd0, i});
                state_d = WT_SYM;
            end
            WT_SYM:  state_d = mem_data_R[7] ? DONE : RD_LEN;
            RD_LEN:  begin
                req     = mem_read(LEN_BASE + {8'd0, sym});
                state_d = WT_LEN;
            end
            WT_LEN:  state_d = len_bad ? DONE : RD_CODE;
            RD_CODE: begin
                req     = mem_read(CODE_BASE + {8'd0, sym});
                state_d = WT_CODE;
            end
            WT_CODE: state_d = MERGE;
            MERGE:   begin
                if (byte_ready)  state_d = WR_BYTE;
                else if (last)   state_d = FLUSH;
                else             state_d = RD_SYM;
            end
            WR_BYTE: begin
                req     = mem_write(DST_BASE + {5'd0, j}, byte_out);
                state_d = WT_W;
            end
            WT_W:    state_d = last ? FLUSH : RD_SYM;
            FLUSH:   begin
                // Bits below nb are already zero, so the partial byte is padded.
                if (nb != 4'd0) req = mem_write(DST_BASE + {5'd0, j}, byte_out);
                state_d = WT_F;
            end
`ifdef HUFF_ENC_TRAILER_EN
            WT_F:    state_d = TRAIL;
            TRAIL:   begin
                req     = mem_write(DST_BASE + {5'd0, j}, trailer_val);
                state_d = WT_T;
            end
            WT_T:    state_d = DONE;
`else
            WT_F:    state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 10'd0;
            i        <= 10'd0;
            j        <= 11'd0;
            sym      <= 8'd0;
            len      <= 4'd0;
            code     <= 8'd0;
            out_bits <= 13'd0;
            error    <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (start) begin
                    cnt      <= sym_count;
                    i        <= 10'd0;
                    j        <= 11'd0;
                    out_bits <= 13'd0;
                    error    <= 1'b0;
                end
                WT_SYM: begin
                    sym <= mem_data_R;
                    if (mem_data_R[7]) error <= 1'b1;
                end
                WT_LEN: begin
                    len <= mem_data_R[3:0];
                    if (len_bad) error <= 1'b1;
                end
                WT_CODE: code <= mem_data_R;
                MERGE: begin
                    out_bits <= out_bits + {9'd0, len};
                    if (!byte_ready && !last) i <= i + 10'd1;
                end
                WR_BYTE: j <= j + 11'd1;
                WT_W:    if (!last) i <= i + 10'd1;
                FLUSH:   if (nb != 4'd0) j <= j + 11'd1;
                default: ;
            endcase
        end
    end

    assign mem_addr   = req.addr;
    assign mem_data_W = req.wdata;
    assign mem_R      = req.rd;
    assign mem_W      = req.wr;
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_huff_encode.sv
// Bench for huff_encode: table-driven vectors, hand sequences for reset abort and
// ignored restart, and randomized runs against a bit-queue reference model.
module tb_huff_encode;

`ifdef HUFF_ENC_TRAILER_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  sym_count;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_R = 8'd0;
    logic [7:0]  mem_data_W;
    logic        mem_R;
    logic        mem_W;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] out_bits;

    always #5 clk = ~clk;

    huff_encode dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sym_count  (sym_count),
        .mem_addr   (mem_addr),
        .mem_data_R (mem_data_R),
        .mem_data_W (mem_data_W),
        .mem_R      (mem_R),
        .mem_W      (mem_W),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .out_bits   (out_bits)
    );

    // Single-port memory; the bench preloads through its own port while the DUT idles.
    logic [7:0]  mem [0:65535];
    logic        tb_we = 1'b0;
    logic [15:0] tb_addr = 16'd0;
    logic [7:0]  tb_data = 8'd0;
    int          wr_cnt = 0;
    int          overlap = 0;

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        if (mem_W) begin
            mem[mem_addr] <= mem_data_W;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_R) mem_data_R <= mem[mem_addr];
    end

    always @(negedge clk) if (mem_R && mem_W) overlap <= overlap + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge clk);
        #1;
        tb_we   = 1'b0;
    endtask

    // Reference state: table copy, symbol string and expected results.
    logic [7:0] ref_len  [0:255];
    logic [7:0] ref_code [0:255];
    logic [7:0] src_q [$];
    logic [7:0] exp_q [$];
    int exp_bits, exp_err, exp_cyc;

    task automatic set_entry(input int s, input int l, input int c);
        ref_len[s]  = 8'(l);
        ref_code[s] = 8'(c);
        poke(16'(s), 8'(l));
        poke(16'(128 + s), 8'(c));
    endtask

    task automatic load_src();
        foreach (src_q[k]) poke(16'(1024 + k), src_q[k]);
    endtask

    task automatic prefill_dst(input int n);
        for (int k = 0; k < n; k++) poke(16'(2048 + k), 8'hEE);
    endtask

    // Concatenate code bits into one bit queue, emit bytes as they fill, pad the tail.
    task automatic ref_model(input int n);
        bit         bq [$];
        logic [7:0] b;
        logic [7:0] s;
        int         l;
        exp_q.delete();
        exp_bits = 0;
        exp_err  = 0;
        exp_cyc  = 1;
        for (int k = 0; k < n; k++) begin
            s = src_q[k];
            exp_cyc += 2;
            if (s >= 8'd128) begin exp_err = 1; break; end
            l = int'(ref_len[s]);
            exp_cyc += 2;
            if (l == 0 || l > 8) begin exp_err = 1; break; end
            exp_cyc  += 3;
            exp_bits += l;
            for (int t = 0; t < l; t++) bq.push_back(ref_code[s][7 - t]);
            if (bq.size() >= 8) begin
                for (int t = 0; t < 8; t++) b[7 - t] = bq.pop_front();
                exp_q.push_back(b);
                exp_cyc += 2;
            end
        end
        if (exp_err == 0 && n > 0) begin
            exp_cyc += 2;
            if (bq.size() > 0) begin
                b = 8'd0;
                for (int t = 0; t < bq.size(); t++) b[7 - t] = bq[t];
                exp_q.push_back(b);
            end
            if (TRAIL) begin
                exp_cyc += 2;
                exp_q.push_back(8'((exp_bits == 0) ? 0 : ((exp_bits - 1) % 8) + 1));
            end
        end
    endtask

    task automatic run_enc(input string tag, input int n, input int restart_at,
                           output int ob, output int er, output int cyc, output int nwr, output bit to);
        int w0;
        w0        = wr_cnt;
        sym_count = 10'(n);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        sym_count = 10'($urandom_range(0, 1023));
        cyc       = 1;
        if (n > 0) check({tag, "_busy_after_start"}, int'(busy), 1);
        while (!done && cyc < 3000) begin
            if (cyc == restart_at) begin
                start     = 1'b1;
                sym_count = 10'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        to  = !done;
        ob  = int'(out_bits);
        er  = int'(error);
        nwr = wr_cnt - w0;
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_busy_after_done"}, int'(busy), 0);
    endtask

    task automatic compare(input string tag, input int ob, input int er, input int cyc, input int nwr, input bit to);
        check({tag, "_timeout"}, int'(to), 0);
        check({tag, "_out_bits"}, ob, exp_bits);
        check({tag, "_error"}, er, exp_err);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_writes"}, nwr, exp_q.size());
        foreach (exp_q[k])
            check($sformatf("%s_byte%0d", tag, k), int'(mem[16'(2048 + k)]), int'(exp_q[k]));
        check({tag, "_guard"}, int'(mem[16'(2048 + exp_q.size())]), 8'hEE);
    endtask

    typedef struct {
        int         n;
        logic [7:0] s0, s1, s2, s3;
        int         bits;
        int         err;
        int         nbytes;
        logic [7:0] b0, b1;
    } vec_t;

    initial begin
        vec_t vt [8];
        int   ob, er, cyc, nwr, act, n;
        bit   to;
        logic [7:0] s;

        rst       = 1'b1;
        start     = 1'b0;
        sym_count = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        check("reset_out_bits", int'(out_bits), 0);
        check("reset_strobes", int'({mem_R, mem_W}), 0);
        check("reset_mem_addr", int'(mem_addr), 0);
        rst = 1'b0;

        set_entry(0, 2, 8'h40);
        set_entry(1, 4, 8'hB0);
        set_entry(2, 4, 8'hA0);
        set_entry(3, 2, 8'h00);
        set_entry(4, 3, 8'h80);
        set_entry(5, 2, 8'hC0);
        set_entry(6, 9, 8'hFF);
        set_entry(7, 0, 8'h55);

        vt[0] = '{3, 8'd0, 8'd5,   8'd1, 8'd0, 8,  0, 1, 8'h7B, 8'h00};
        vt[1] = '{2, 8'd4, 8'd3,   8'd0, 8'd0, 5,  0, 1, 8'h80, 8'h00};
        vt[2] = '{3, 8'd1, 8'd2,   8'd1, 8'd0, 12, 0, 2, 8'hBA, 8'hB0};
        vt[3] = '{2, 8'd0, 8'd200, 8'd0, 8'd0, 2,  1, 0, 8'h00, 8'h00};
        vt[4] = '{1, 8'd6, 8'd0,   8'd0, 8'd0, 0,  1, 0, 8'h00, 8'h00};
        vt[5] = '{1, 8'd7, 8'd0,   8'd0, 8'd0, 0,  1, 0, 8'h00, 8'h00};
        vt[6] = '{0, 8'd0, 8'd0,   8'd0, 8'd0, 0,  0, 0, 8'h00, 8'h00};
        vt[7] = '{4, 8'd5, 8'd5,   8'd5, 8'd5, 8,  0, 1, 8'hFF, 8'h00};

        for (int v = 0; v < 8; v++) begin
            src_q = '{vt[v].s0, vt[v].s1, vt[v].s2, vt[v].s3};
            load_src();
            prefill_dst(5);
            ref_model(vt[v].n);
            exp_bits = vt[v].bits;
            exp_err  = vt[v].err;
            exp_q.delete();
            if (vt[v].nbytes >= 1) exp_q.push_back(vt[v].b0);
            if (vt[v].nbytes >= 2) exp_q.push_back(vt[v].b1);
            if (TRAIL && vt[v].err == 0 && vt[v].n > 0)
                exp_q.push_back(8'((vt[v].bits == 0) ? 0 : ((vt[v].bits - 1) % 8) + 1));
            run_enc($sformatf("vec%0d", v), vt[v].n, -1, ob, er, cyc, nwr, to);
            compare($sformatf("vec%0d", v), ob, er, cyc, nwr, to);
        end

        // A start pulse while busy must not disturb the run in progress.
        src_q = '{8'd0, 8'd5, 8'd1};
        load_src();
        prefill_dst(5);
        ref_model(3);
        run_enc("restart", 3, 5, ob, er, cyc, nwr, to);
        compare("restart", ob, er, cyc, nwr, to);
        check("restart_byte_const", int'(mem[16'd2048]), 8'h7B);

        // Reset while the first byte write is on the bus, then a fresh run.
        src_q = '{8'd1, 8'd2, 8'd1};
        load_src();
        sym_count = 10'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        act   = 0;
        while (!mem_W && act < 200) begin
            @(posedge clk);
            #1;
            act++;
        end
        check("rst_reach_wr_byte", int'(mem_W), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_abort_out_bits", int'(out_bits), 0);
        check("rst_abort_mem_addr", int'(mem_addr), 0);
        act = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (mem_R || mem_W || done || busy) act++;
        end
        check("rst_abort_quiet", act, 0);
        src_q = '{8'd3};
        load_src();
        prefill_dst(5);
        ref_model(1);
        run_enc("rst_rerun", 1, -1, ob, er, cyc, nwr, to);
        compare("rst_rerun", ob, er, cyc, nwr, to);
        check("rst_rerun_byte_const", int'(mem[16'd2048]), 8'h00);
        check("rst_rerun_bits_const", ob, 2);

        // Randomized tables (unmasked low code bits, occasional bad lengths) and strings.
        for (int r = 0; r < 12; r++) begin
            for (int t = 0; t < 16; t++) begin
                int l;
                l = int'($urandom_range(1, 8));
                if ($urandom_range(0, 19) == 0) l = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15));
                set_entry(t, l, int'($urandom_range(0, 255)));
            end
            n = int'($urandom_range(1, 24));
            src_q.delete();
            for (int k = 0; k < n; k++) begin
                s = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 39) == 0) s = 8'(128 + $urandom_range(0, 127));
                src_q.push_back(s);
            end
            load_src();
            prefill_dst(28);
            ref_model(n);
            run_enc($sformatf("rand%0d", r), n, -1, ob, er, cyc, nwr, to);
            compare($sformatf("rand%0d", r), ob, er, cyc, nwr, to);
        end

        check("strobe_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
